qubit_measure: RTL and testbench

//  Z-basis measurement unit: the reading end of the single-qubit gate datapath.
//  - Accepts a qubit state (alpha, beta), each amplitude a complex signed fixed-point

---
 rtl/qubit_pkg.sv | 26 ++
 rtl/qubit_measure_if.sv | 33 +++
 rtl/qubit_measure_fx_mult.sv | 18 +
 rtl/qubit_measure.sv | 196 +++++++++++++++++++
 tb/tb_qubit_measure.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/qubit_pkg.sv
// Shared constants and types for the single-qubit gate library.
// Amplitudes are Q2.14 signed fixed point.
package qubit_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 14;
  localparam int P_W    = 2 * DATA_W - FRAC_W;
  localparam int MUL_W  = 18;
  localparam int PROD_W = 36;

  localparam logic [DATA_W-1:0] FX_ONE    = 16'h4000;
  localparam logic [15:0]       LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SQ     = 3'd1,
    ST_SCALE  = 3'd2,
    ST_DECIDE = 3'd3,
    ST_HOLD   = 3'd4
  } meas_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/qubit_measure_if.sv
// State-in / result-out handshake bundle of the measurement unit.
interface qubit_measure_if;
  import qubit_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alpha_re;
  logic [DATA_W-1:0] alpha_im;
  logic [DATA_W-1:0] beta_re;
  logic [DATA_W-1:0] beta_im;
  logic              out_valid;
  logic              out_ready;
  logic              meas_bit;
  logic [15:0]       prob0;
  logic              zero_norm;
  logic [DATA_W-1:0] out_alpha_re;
  logic [DATA_W-1:0] out_alpha_im;
  logic [DATA_W-1:0] out_beta_re;
  logic [DATA_W-1:0] out_beta_im;

  modport master (
    output in_valid, alpha_re, alpha_im, beta_re, beta_im, out_ready,
    input  in_ready, out_valid, meas_bit, prob0, zero_norm,
           out_alpha_re, out_alpha_im, out_beta_re, out_beta_im
  );

  modport slave (
    input  in_valid, alpha_re, alpha_im, beta_re, beta_im, out_ready,
    output in_ready, out_valid, meas_bit, prob0, zero_norm,
           out_alpha_re, out_alpha_im, out_beta_re, out_beta_im
  );

endinterface

// File: rtl/qubit_measure_fx_mult.sv
// Combinational 18x18 multiplier; sgn selects sign- or zero-extension of both operands.
module fx_mult
  import qubit_pkg::*;
(
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  input  logic              sgn,
  output logic [PROD_W-1:0] p
);

  logic signed [PROD_W-1:0] a_x;
  logic signed [PROD_W-1:0] b_x;

  assign a_x = {{(PROD_W-MUL_W){sgn & a[MUL_W-1]}}, a};
  assign b_x = {{(PROD_W-MUL_W){sgn & b[MUL_W-1]}}, b};
  assign p   = a_x * b_x;

endmodule

// File: rtl/qubit_measure.sv
// Z-basis measurement: |alpha|^2 and |beta|^2 on one shared multiplier, LFSR-driven sample,
// collapsed basis state held until the consumer accepts it.
//
//   state     | meaning
//   ST_IDLE   | ready for a new state; accept latches inputs and steps the LFSR
//   ST_SQ     | four signed squares (ar, ai, br, bi), cnt 0..3
//   ST_SCALE  | thr = (r * psum) >> FRAC_W
//   ST_DECIDE | compare thr against p0, load result registers
//   ST_HOLD   | out_valid until out_ready
module qubit_measure
  import qubit_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst_n,
  qubit_measure_if.slave bus
);

  localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int          ACC_W = 2 * DATA_W;

  meas_state_e       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [DATA_W-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic [ACC_W-1:0]  acc0_q, acc0_d, acc1_q, acc1_d;
  logic [P_W-1:0]    thr_q, thr_d;
  logic              out_valid_q, out_valid_d;
  logic              meas_q, meas_d;
  logic              zn_q, zn_d;
  logic [15:0]       prob0_q, prob0_d;
  logic [DATA_W-1:0] oar_q, oar_d, oai_q, oai_d, obr_q, obr_d, obi_q, obi_d;

  logic [P_W-1:0]    p0, p1;
  logic [P_W:0]      psum;
  logic [DATA_W-1:0] sq_op;
  logic [MUL_W-1:0]  mul_a, mul_b;
  logic              mul_sgn;
  logic [PROD_W-1:0] mul_p;
  logic              unused_mul_hi;
  logic              meas_c;

  // Sums are kept at full precision and truncated only once, after both squares.
  assign p0   = acc0_q[ACC_W-1:FRAC_W];
  assign p1   = acc1_q[ACC_W-1:FRAC_W];
  assign psum = {1'b0, p0} + {1'b0, p1};

  always_comb begin
    case (cnt_q)
      2'd0:    sq_op = ar_q;
      2'd1:    sq_op = ai_q;
      2'd2:    sq_op = br_q;
      default: sq_op = bi_q;
    endcase
    if (state_q == ST_SCALE) begin
      // psum only exceeds 18 bits when every component is -2.0; clamp that corner.
      mul_a   = {{(MUL_W-FRAC_W){1'b0}}, lfsr_q[FRAC_W-1:0]};
      mul_b   = psum[P_W] ? {MUL_W{1'b1}} : psum[MUL_W-1:0];
      mul_sgn = 1'b0;
    end else begin
      mul_a   = {{(MUL_W-DATA_W){sq_op[DATA_W-1]}}, sq_op};
      mul_b   = mul_a;
      mul_sgn = 1'b1;
    end
  end

  fx_mult u_mult (
    .a   (mul_a),
    .b   (mul_b),
    .sgn (mul_sgn),
    .p   (mul_p)
  );

  assign unused_mul_hi = ^mul_p[PROD_W-1:ACC_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    ar_d        = ar_q;
    ai_d        = ai_q;
    br_d        = br_q;
    bi_d        = bi_q;
    acc0_d      = acc0_q;
    acc1_d      = acc1_q;
    thr_d       = thr_q;
    out_valid_d = out_valid_q;
    meas_d      = meas_q;
    zn_d        = zn_q;
    prob0_d     = prob0_q;
    oar_d       = oar_q;
    oai_d       = oai_q;
    obr_d       = obr_q;
    obi_d       = obi_q;
    meas_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          ar_d    = bus.alpha_re;
          ai_d    = bus.alpha_im;
          br_d    = bus.beta_re;
          bi_d    = bus.beta_im;
          acc0_d  = '0;
          acc1_d  = '0;
          cnt_d   = 2'd0;
          lfsr_d  = lfsr_step(lfsr_q);
          state_d = ST_SQ;
        end
      end
      ST_SQ: begin
        if (!cnt_q[1]) acc0_d = acc0_q + mul_p[ACC_W-1:0];
        else           acc1_d = acc1_q + mul_p[ACC_W-1:0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_SCALE;
      end
      ST_SCALE: begin
        thr_d   = mul_p[FRAC_W +: P_W];
        state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        zn_d        = (psum == '0);
        meas_c      = (psum != '0) && (thr_q >= p0);
        meas_d      = meas_c;
        prob0_d     = (p0 > P_W'(16'hFFFF)) ? 16'hFFFF : p0[15:0];
        oar_d       = meas_c ? '0 : FX_ONE;
        oai_d       = '0;
        obr_d       = meas_c ? FX_ONE : '0;
        obi_d       = '0;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lfsr_q      <= SEED;
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      acc0_q      <= '0;
      acc1_q      <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      meas_q      <= 1'b0;
      zn_q        <= 1'b0;
      prob0_q     <= '0;
      oar_q       <= '0;
      oai_q       <= '0;
      obr_q       <= '0;
      obi_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      ar_q        <= ar_d;
      ai_q        <= ai_d;
      br_q        <= br_d;
      bi_q        <= bi_d;
      acc0_q      <= acc0_d;
      acc1_q      <= acc1_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      meas_q      <= meas_d;
      zn_q        <= zn_d;
      prob0_q     <= prob0_d;
      oar_q       <= oar_d;
      oai_q       <= oai_d;
      obr_q       <= obr_d;
      obi_q       <= obi_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.meas_bit     = meas_q;
  assign bus.zero_norm    = zn_q;
  assign bus.prob0        = prob0_q;
  assign bus.out_alpha_re = oar_q;
  assign bus.out_alpha_im = oai_q;
  assign bus.out_beta_re  = obr_q;
  assign bus.out_beta_im  = obi_q;

endmodule

// File: tb/tb_qubit_measure.sv
// Bench for qubit_measure: fixed vectors, random states against a probability model,
// |+> statistics, backpressure and mid-flight reset.
module tb_qubit_measure;
  import qubit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qubit_measure_if bus ();

  qubit_measure #(.LFSR_SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        meas;
    logic [15:0] prob0;
    logic        zn;
  } res_t;

  typedef struct {
    logic [15:0] ar, ai, br, bi;
    logic        meas;
    logic [15:0] prob0;
    logic        zn;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] lfsr_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Probability-level reference: integer squares, truncating shifts, threshold compare.
  function automatic res_t model(input logic signed [15:0] ar, ai, br, bi, input logic [15:0] l);
    longint p0, p1, psum, r, thr;
    res_t o;
    p0   = (longint'(ar) * ar + longint'(ai) * ai) >>> 14;
    p1   = (longint'(br) * br + longint'(bi) * bi) >>> 14;
    psum = p0 + p1;
    r    = longint'(l) % 16384;
    thr  = (r * psum) >>> 14;
    o.zn    = (psum == 0);
    o.meas  = (psum != 0) && (thr >= p0);
    o.prob0 = (p0 > 65535) ? 16'hFFFF : 16'(p0);
    return o;
  endfunction

  task automatic do_meas(input logic [15:0] ar, ai, br, bi, output res_t got);
    res_t ex;
    int   n;
    bit   seen;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.alpha_re = ar;
    bus.alpha_im = ai;
    bus.beta_re  = br;
    bus.beta_im  = bi;
    lfsr_m = lfsr_next(lfsr_m);
    ex = model(ar, ai, br, bi, lfsr_m);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.out_valid;
    end
    chk("latency_edges", n, 6);
    got.meas  = bus.meas_bit;
    got.prob0 = bus.prob0;
    got.zn    = bus.zero_norm;
    chk("meas_bit", bus.meas_bit, ex.meas);
    chk("prob0", bus.prob0, ex.prob0);
    chk("zero_norm", bus.zero_norm, ex.zn);
    chk("out_alpha_re", bus.out_alpha_re, ex.meas ? 16'h0000 : 16'h4000);
    chk("out_alpha_im", bus.out_alpha_im, 0);
    chk("out_beta_re", bus.out_beta_re, ex.meas ? 16'h4000 : 16'h0000);
    chk("out_beta_im", bus.out_beta_im, 0);
    if (bus.out_ready) begin
      @(posedge clk);
      #1 chk("out_valid_drop", bus.out_valid, 0);
    end
  endtask

  initial begin
    vec_t        tbl[10];
    res_t        g;
    int          ones;
    int          v;
    logic [15:0] a0, a1, a2, a3;
    logic [63:0] snap_amp;
    logic [17:0] snap_misc;
    bit          saw_valid;

    tbl[0] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h4000, 1'b0};
    tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 1'b1, 16'h0000, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1};
    tbl[3] = '{16'h0000, 16'h4000, 16'h0000, 16'h0000, 1'b0, 16'h4000, 1'b0};
    tbl[4] = '{16'hC000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h4000, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 16'hC000, 16'h0000, 1'b1, 16'h0000, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b1};
    tbl[8] = '{16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0};
    tbl[9] = '{16'h0000, 16'h0000, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alpha_re  = '0;
    bus.alpha_im  = '0;
    bus.beta_re   = '0;
    bus.beta_im   = '0;
    lfsr_m        = 16'hACE1;

    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_results", {bus.meas_bit, bus.zero_norm, bus.prob0}, 0);
    chk("rst_amps", {bus.out_alpha_re, bus.out_alpha_im, bus.out_beta_re, bus.out_beta_im}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_meas(tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, g);
      chk($sformatf("tbl%0d_meas", i), g.meas, tbl[i].meas);
      chk($sformatf("tbl%0d_prob0", i), g.prob0, tbl[i].prob0);
      chk($sformatf("tbl%0d_zero_norm", i), g.zn, tbl[i].zn);
    end

    for (int i = 0; i < 300; i++) begin
      v = int'($urandom_range(0, 32768)) - 16384; a0 = 16'(v);
      v = int'($urandom_range(0, 32768)) - 16384; a1 = 16'(v);
      v = int'($urandom_range(0, 32768)) - 16384; a2 = 16'(v);
      v = int'($urandom_range(0, 32768)) - 16384; a3 = 16'(v);
      do_meas(a0, a1, a2, a3, g);
    end

    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      do_meas(16'h2D41, 16'h0000, 16'h2D41, 16'h0000, g);
      if (g.prob0 !== 16'h1FFF) chk("plus_prob0", g.prob0, 16'h1FFF);
      if (g.meas === 1'b1) ones++;
    end
    chk("plus_ones_within_450_550", (ones >= 450 && ones <= 550), 1);

    // Backpressure: result held, new input refused, LFSR frozen.
    bus.out_ready = 1'b0;
    do_meas(16'h2D41, 16'h0000, 16'h0000, 16'h2D41, g);
    snap_amp  = {bus.out_alpha_re, bus.out_alpha_im, bus.out_beta_re, bus.out_beta_im};
    snap_misc = {bus.meas_bit, bus.zero_norm, bus.prob0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alpha_re = 16'h1234;
      bus.beta_re  = 16'h0321;
      @(posedge clk);
      #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_amps_stable", {bus.out_alpha_re, bus.out_alpha_im, bus.out_beta_re, bus.out_beta_im}, snap_amp);
      chk("bp_misc_stable", {bus.meas_bit, bus.zero_norm, bus.prob0}, snap_misc);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_release_handshake", bus.out_valid, 0);
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (bus.out_valid) saw_valid = 1;
    end
    chk("bp_no_extra_result", saw_valid, 0);
    chk("bp_idle_after", bus.in_ready, 1);
    for (int i = 0; i < 16; i++) do_meas(16'h2D41, 16'h0000, 16'h2D41, 16'h0000, g);

    // Reset while squaring: old result cleared at once, nothing emitted, LFSR back to seed.
    do_meas(16'h0000, 16'h0000, 16'h0000, 16'h4000, g);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alpha_re = 16'h2D41;
    bus.alpha_im = 16'h0000;
    bus.beta_re  = 16'h2D41;
    bus.beta_im  = 16'h0000;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_results", {bus.meas_bit, bus.zero_norm, bus.prob0}, 0);
    chk("midrst_amps", {bus.out_alpha_re, bus.out_alpha_im, bus.out_beta_re, bus.out_beta_im}, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    lfsr_m = 16'hACE1;
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (bus.out_valid) saw_valid = 1;
    end
    chk("midrst_no_partial_result", saw_valid, 0);
    for (int i = 0; i < 8; i++) do_meas(16'h2D41, 16'h0000, 16'h2D41, 16'h0000, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
